// File: rtl/fir_decim_out.sv
// FIR output conditioning: round, saturate, decimate and buffer filter results
// in a first-word-fall-through FIFO with sticky saturation/overflow flags.
module fir_decim_out #(
    parameter int SHIFT = 15,
    parameter int OUT_W = 16,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [31:0]         in_data,
    input  logic                       clear_flags,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [OUT_W-1:0]    m_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       sat_flag,
    output logic                       ovf_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [32:0] ROUND_V = 33'sd1 <<< (SHIFT - 1);
    localparam logic signed [32:0] MAX_V   = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
    localparam logic signed [32:0] MIN_V   = -(33'sd1 <<< (OUT_W - 1));

    logic signed [32:0]      ext_s;
    logic signed [32:0]      rnd_s;
    logic signed [32:0]      shf_s;
    logic signed [OUT_W-1:0] sat_val_s;
    logic                    sat_s;
    logic                    keep_s;

    logic [PW-1:0]           phase_r;
    logic signed [OUT_W-1:0] s1_data_r;
    logic                    s1_keep_r;
    logic                    s1_sat_r;

    logic signed [OUT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]           wr_ptr_r;
    logic [AW-1:0]           rd_ptr_r;
    logic [LW-1:0]           level_r;
    logic                    sat_flag_r;
    logic                    ovf_flag_r;

    logic                    full_s;
    logic                    pop_s;
    logic                    do_write_s;
    logic                    drop_s;

    // Round half toward +inf, then clamp into the signed output range.
    always_comb begin
        ext_s  = {in_data[31], in_data};
        rnd_s  = ext_s + ROUND_V;
        shf_s  = rnd_s >>> SHIFT;
        keep_s = in_valid && (phase_r == '0);
        if (shf_s > MAX_V) begin
            sat_val_s = MAX_V[OUT_W-1:0];
            sat_s     = 1'b1;
        end else if (shf_s < MIN_V) begin
            sat_val_s = MIN_V[OUT_W-1:0];
            sat_s     = 1'b1;
        end else begin
            sat_val_s = shf_s[OUT_W-1:0];
            sat_s     = 1'b0;
        end
    end

    // Decimation phase and stage-1 pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r   <= '0;
            s1_data_r <= '0;
            s1_keep_r <= 1'b0;
            s1_sat_r  <= 1'b0;
        end else begin
            if (in_valid) begin
                if (phase_r == PW'(DECIM - 1)) begin
                    phase_r <= '0;
                end else begin
                    phase_r <= phase_r + PW'(1);
                end
            end
            s1_data_r <= sat_val_s;
            s1_keep_r <= keep_s;
            s1_sat_r  <= sat_s;
        end
    end

    // FIFO handshake decode: a full FIFO still accepts a write when it pops.
    always_comb begin
        full_s     = (level_r == LW'(DEPTH));
        pop_s      = (level_r != '0) && m_ready;
        do_write_s = s1_keep_r && (!full_s || pop_s);
        drop_s     = s1_keep_r && full_s && !pop_s;
    end

    // FIFO storage; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            mem_r[wr_ptr_r] <= s1_data_r;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_write_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_write_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag_r <= 1'b0;
            ovf_flag_r <= 1'b0;
        end else begin
            if (s1_keep_r && s1_sat_r) begin
                sat_flag_r <= 1'b1;
            end else if (clear_flags) begin
                sat_flag_r <= 1'b0;
            end else begin
                sat_flag_r <= sat_flag_r;
            end
            if (drop_s) begin
                ovf_flag_r <= 1'b1;
            end else if (clear_flags) begin
                ovf_flag_r <= 1'b0;
            end else begin
                ovf_flag_r <= ovf_flag_r;
            end
        end
    end

    // Output view of the FIFO head, forced to zero while empty.
    always_comb begin
        m_valid  = (level_r != '0);
        level    = level_r;
        sat_flag = sat_flag_r;
        ovf_flag = ovf_flag_r;
        if (level_r != '0) begin
            m_data = mem_r[rd_ptr_r];
        end else begin
            m_data = '0;
        end
    end

endmodule
